// File: rtl/gf180mcu_fd_io__out_seq.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_io__out_seq
//
// Transmit-side sequencer for one bidirectional pad. It registers core data
// onto the pad driver, sequences the output-enable turnaround so the pad
// pull-up/pull-down is always released before any driver finger turns on (and
// the driver is off before pulls return), staggers the driver-finger enables
// to limit di/dt, and checks the driven value against the receiver loopback.
//
// Parameters:
//   TURN_CYC  - break-before-make wait between pulls and driver, cycles (>=1)
//   RAMP_STEP - cycles between successive finger enables (>=1)
//   NFING     - number of driver fingers (>=1)
//   CHK_CYC   - cycles DO must be stable before the loopback compare (>=3)
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RSTN       in   asynchronous active-low reset
//   A          in   core data to drive
//   OE         in   core output-enable request
//   PU_REQ     in   core pull-up request (honoured only while not driving)
//   PD_REQ     in   core pull-down request (honoured only while not driving)
//   Y          in   asynchronous loopback from the pad receiver
//   FAULT_CLR  in   clears FAULT (a simultaneous set wins)
//   DO         out  registered data to the pad driver
//   EN         out  per-finger driver enables, thermometer coded from bit 0
//   PU, PD     out  pull controls to the pad
//   BUSY       out  turnaround or ramp in progress
//   FAULT      out  sticky contention flag
//   DVDD, DVSS, VDD, VSS  inout  supplies, no functional role
// -----------------------------------------------------------------------------
module gf180mcu_fd_io__out_seq #(
  parameter int TURN_CYC  = 2,
  parameter int RAMP_STEP = 1,
  parameter int NFING     = 4,
  parameter int CHK_CYC   = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             A,
  input  logic             OE,
  input  logic             PU_REQ,
  input  logic             PD_REQ,
  input  logic             Y,
  input  logic             FAULT_CLR,
  output logic             DO,
  output logic [NFING-1:0] EN,
  output logic             PU,
  output logic             PD,
  output logic             BUSY,
  output logic             FAULT,
  inout  wire              DVDD,
  inout  wire              DVSS,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRK_ON  = 3'd1,
    ST_RAMP    = 3'd2,
    ST_DRIVE   = 3'd3,
    ST_BRK_OFF = 3'd4
  } state_e;

  // One down-counter serves both the turnaround wait and the ramp spacing,
  // so it is sized for the larger of the two.
  localparam int MAXC = (TURN_CYC > RAMP_STEP) ? TURN_CYC : RAMP_STEP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] RAMP_LD = CW'(RAMP_STEP - 1);

  localparam int SW = $clog2(CHK_CYC + 1);
  localparam logic [SW-1:0] CHK_MAX = SW'(CHK_CYC);

  // Next thermometer step: shift the enable pattern up and fill bit 0.
  function automatic logic [NFING-1:0] fill_next(input logic [NFING-1:0] en);
    logic [NFING:0] ext;
    ext = {en, 1'b1};
    return ext[NFING-1:0];
  endfunction

  // Pull resolution: requesting both pulls at once would crowbar the pad, so
  // that combination releases both.
  function automatic logic [1:0] resolve_pulls(input logic pu_req, input logic pd_req);
    logic [1:0] r;
    if (pu_req && pd_req) begin
      r = 2'b00;
    end else begin
      r = {pu_req, pd_req};
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NFING-1:0] en_q, en_d;
  logic [NFING-1:0] en_nx_s;
  logic             do_q, do_d;
  logic             pu_q, pu_d;
  logic             pd_q, pd_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             y_meta_q, y_sync_q;
  logic [SW-1:0]    stab_q, stab_d;
  logic             chk_s;
  logic [1:0]       pulls_s;

  // Sequencer next-state: turnaround, finger ramp and abort handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    en_nx_s = fill_next(en_q);
    case (state_q)
      ST_IDLE: begin
        en_d = '0;
        if (OE) begin
          state_d = ST_BRK_ON;
          cnt_d   = TURN_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BRK_ON: begin
        if (!OE) begin
          state_d = ST_BRK_OFF;
          cnt_d   = TURN_LD;
          en_d    = '0;
        end else if (cnt_q == '0) begin
          // en_q is all zero here, so this sets finger 0; with a single
          // finger that is already the last one.
          en_d    = en_nx_s;
          cnt_d   = RAMP_LD;
          state_d = en_nx_s[NFING-1] ? ST_DRIVE : ST_RAMP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RAMP: begin
        if (!OE) begin
          state_d = ST_BRK_OFF;
          cnt_d   = TURN_LD;
          en_d    = '0;
        end else if (cnt_q == '0) begin
          en_d    = en_nx_s;
          cnt_d   = RAMP_LD;
          state_d = en_nx_s[NFING-1] ? ST_DRIVE : ST_RAMP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRIVE: begin
        if (!OE) begin
          state_d = ST_BRK_OFF;
          cnt_d   = TURN_LD;
          en_d    = '0;
        end else begin
          en_d = '1;
        end
      end
      ST_BRK_OFF: begin
        // OE is deliberately ignored: the full turnaround always completes.
        en_d = '0;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        en_d    = '0;
      end
    endcase
  end

  // Output next-values: pulls follow the requests only in (or on entry to)
  // IDLE, BUSY covers every transitional state, DO simply registers A.
  always_comb begin
    do_d    = A;
    pulls_s = resolve_pulls(PU_REQ, PD_REQ);
    if (state_d == ST_IDLE) begin
      pu_d = pulls_s[1];
      pd_d = pulls_s[0];
    end else begin
      pu_d = 1'b0;
      pd_d = 1'b0;
    end
    busy_d = (state_d == ST_BRK_ON) || (state_d == ST_RAMP) || (state_d == ST_BRK_OFF);
  end

  // Contention check: DO stability counter and sticky fault flag.
  always_comb begin
    if (A != do_q) begin
      stab_d = '0;
    end else if (stab_q != CHK_MAX) begin
      stab_d = stab_q + SW'(1);
    end else begin
      stab_d = stab_q;
    end
    // The synchronized loopback is only trusted once DO has been stable long
    // enough to cover pad delay plus the two synchronizer stages.
    chk_s = (state_q == ST_DRIVE) && (stab_q >= CHK_MAX) && (y_sync_q != do_q);
    if (chk_s) begin
      fault_d = 1'b1;
    end else if (FAULT_CLR) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // Sequencer state, counter and finger enables; reset releases the driver
  // immediately, without waiting for a clock.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  // Registered pad-facing outputs and the contention-check state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      do_q    <= 1'b0;
      pu_q    <= 1'b0;
      pd_q    <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      stab_q  <= '0;
    end else begin
      do_q    <= do_d;
      pu_q    <= pu_d;
      pd_q    <= pd_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      stab_q  <= stab_d;
    end
  end

  // Two-flop synchronizer for the asynchronous receiver loopback.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      y_meta_q <= 1'b0;
      y_sync_q <= 1'b0;
    end else begin
      y_meta_q <= Y;
      y_sync_q <= y_meta_q;
    end
  end

  assign DO    = do_q;
  assign EN    = en_q;
  assign PU    = pu_q;
  assign PD    = pd_q;
  assign BUSY  = busy_q;
  assign FAULT = fault_q;

endmodule

// File: tb/tb_gf180mcu_fd_io__out_seq.sv
// -----------------------------------------------------------------------------
// Bench for gf180mcu_fd_io__out_seq. Two instances share all inputs: u0 with
// default parameters, u1 with NFING=1, RAMP_STEP=3, TURN_CYC=1. A timeline
// model (times of OE acceptance / release, count of fingers due by now) gives
// the expected outputs; a compare process checks every cycle and directed
// literal checks pin the documented timing.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_io__out_seq;

  localparam int T_P [2] = '{2, 1};
  localparam int R_P [2] = '{1, 3};
  localparam int N_P [2] = '{4, 1};
  localparam int CHK = 3;

  logic clk = 1'b0;
  logic rstn, a, oe, pu_req, pd_req, fault_clr;
  logic a_dly, y_force_en, y_force_val;
  logic y;
  wire  dvdd, dvss, vdd, vss;

  logic       do0, pu0, pd0, busy0, fault0;
  logic [3:0] en0;
  logic       do1, pu1, pd1, busy1, fault1;
  logic [0:0] en1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state.
  int         e;
  int         lc;
  logic       m_do, y1, y2;
  int         mode [2];   // 0 idle, 1 on (turnaround/ramp/drive), 2 off
  int         kst  [2];
  int         mst  [2];
  logic [3:0] m_en [2];
  logic       m_pu [2], m_pd [2], m_busy [2], m_fault [2], m_drv [2];

  assign y = y_force_en ? y_force_val : a_dly;

  always #5 clk = ~clk;

  gf180mcu_fd_io__out_seq u0 (
    .CLK(clk), .RSTN(rstn), .A(a), .OE(oe), .PU_REQ(pu_req), .PD_REQ(pd_req),
    .Y(y), .FAULT_CLR(fault_clr), .DO(do0), .EN(en0), .PU(pu0), .PD(pd0),
    .BUSY(busy0), .FAULT(fault0), .DVDD(dvdd), .DVSS(dvss), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_io__out_seq #(.TURN_CYC(1), .RAMP_STEP(3), .NFING(1), .CHK_CYC(3)) u1 (
    .CLK(clk), .RSTN(rstn), .A(a), .OE(oe), .PU_REQ(pu_req), .PD_REQ(pd_req),
    .Y(y), .FAULT_CLR(fault_clr), .DO(do1), .EN(en1), .PU(pu1), .PD(pd1),
    .BUSY(busy1), .FAULT(fault1), .DVDD(dvdd), .DVSS(dvss), .VDD(vdd), .VSS(vss)
  );

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0; lc = 0; m_do = 1'b0; y1 = 1'b0; y2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; kst[i] = 0; mst[i] = 0; m_en[i] = 4'd0;
      m_pu[i] = 1'b0; m_pd[i] = 1'b0; m_busy[i] = 1'b0;
      m_fault[i] = 1'b0; m_drv[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    int stab;
    int f;
    logic ysync;
    e = e + 1;
    stab = e - 1 - lc;
    if (stab > CHK) stab = CHK;
    ysync = y2;
    for (int i = 0; i < 2; i++) begin
      if (m_drv[i] && stab >= CHK && ysync != m_do) m_fault[i] = 1'b1;
      else if (fault_clr) m_fault[i] = 1'b0;
    end
    if (a != m_do) lc = e;
    m_do = a;
    y2 = y1;
    y1 = y;
    for (int i = 0; i < 2; i++) begin
      if (mode[i] == 0) begin
        if (oe) begin mode[i] = 1; kst[i] = e; end
      end else if (mode[i] == 1) begin
        if (!oe) begin mode[i] = 2; mst[i] = e; end
      end else begin
        if (e >= mst[i] + T_P[i]) mode[i] = 0;
      end
      m_en[i] = 4'd0; m_drv[i] = 1'b0; m_busy[i] = 1'b0; m_pu[i] = 1'b0; m_pd[i] = 1'b0;
      if (mode[i] == 1) begin
        f = 0;
        for (int j = 0; j < N_P[i]; j++)
          if (e >= kst[i] + T_P[i] + j * R_P[i]) f++;
        m_en[i]   = 4'((1 << f) - 1);
        m_drv[i]  = (f == N_P[i]);
        m_busy[i] = (f != N_P[i]);
      end else if (mode[i] == 2) begin
        m_busy[i] = 1'b1;
      end else begin
        m_pu[i] = pu_req & ~pd_req;
        m_pd[i] = pd_req & ~pu_req;
      end
    end
  endtask

  // Delayed loopback: Y follows A 1 ns late unless forced.
  initial begin
    a_dly = 1'b0;
    forever begin
      @(a);
      #1 a_dly = a;
    end
  end

  // Reference model, advanced on each active edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        cmp("u0.DO",    {3'b0, do0},    {3'b0, m_do});
        cmp("u0.EN",    en0,            m_en[0]);
        cmp("u0.PU",    {3'b0, pu0},    {3'b0, m_pu[0]});
        cmp("u0.PD",    {3'b0, pd0},    {3'b0, m_pd[0]});
        cmp("u0.BUSY",  {3'b0, busy0},  {3'b0, m_busy[0]});
        cmp("u0.FAULT", {3'b0, fault0}, {3'b0, m_fault[0]});
        cmp("u1.DO",    {3'b0, do1},    {3'b0, m_do});
        cmp("u1.EN",    {3'b0, en1},    m_en[1]);
        cmp("u1.PU",    {3'b0, pu1},    {3'b0, m_pu[1]});
        cmp("u1.PD",    {3'b0, pd1},    {3'b0, m_pd[1]});
        cmp("u1.BUSY",  {3'b0, busy1},  {3'b0, m_busy[1]});
        cmp("u1.FAULT", {3'b0, fault1}, {3'b0, m_fault[1]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1; a = 1'b0; oe = 1'b0; pu_req = 1'b0; pd_req = 1'b0;
    fault_clr = 1'b0; y_force_en = 1'b0; y_force_val = 1'b0;
    #1 rstn = 1'b0;
    #1;
    cmp("rst.EN",    en0,            4'b0000);
    cmp("rst.DO",    {3'b0, do0},    4'd0);
    cmp("rst.PU",    {3'b0, pu0},    4'd0);
    cmp("rst.BUSY",  {3'b0, busy0},  4'd0);
    cmp("rst.FAULT", {3'b0, fault0}, 4'd0);
    pu_req = 1'b1;
    @(negedge clk);
    rstn = 1'b1;

    // Pulls from the first edge; both requested -> both off.
    cyc();
    cmp("pull.PU", {3'b0, pu0}, 4'd1);
    cmp("pull.PD", {3'b0, pd0}, 4'd0);
    cmp("pull.EN", en0, 4'b0000);
    pd_req = 1'b1;
    cyc();
    cmp("crowbar.PU", {3'b0, pu0}, 4'd0);
    cmp("crowbar.PD", {3'b0, pd0}, 4'd0);
    pd_req = 1'b0;
    cyc();

    // Full enable ramp and release.
    oe = 1'b1;
    cyc();  // k
    cmp("k.PU", {3'b0, pu0}, 4'd0);
    cmp("k.BUSY", {3'b0, busy0}, 4'd1);
    cmp("k.EN", en0, 4'b0000);
    cyc();  // k+1
    cmp("k1.u1EN", {3'b0, en1}, 4'd1);
    cmp("k1.u1BUSY", {3'b0, busy1}, 4'd0);
    cyc();  // k+2
    cmp("k2.EN", en0, 4'b0001);
    cmp("k2.model", m_en[0], 4'b0001);
    cyc();
    cmp("k3.EN", en0, 4'b0011);
    cyc();
    cmp("k4.EN", en0, 4'b0111);
    cmp("k4.BUSY", {3'b0, busy0}, 4'd1);
    cyc();
    cmp("k5.EN", en0, 4'b1111);
    cmp("k5.BUSY", {3'b0, busy0}, 4'd0);
    for (int i = 0; i < 12; i++) begin
      a = ~a;
      cyc();
    end
    cmp("toggle.FAULT", {3'b0, fault0}, 4'd0);
    oe = 1'b0;
    cyc();  // m
    cmp("m.EN", en0, 4'b0000);
    cmp("m.BUSY", {3'b0, busy0}, 4'd1);
    cyc();
    cmp("m1.PU", {3'b0, pu0}, 4'd0);
    cyc();
    cmp("m2.PU", {3'b0, pu0}, 4'd1);
    cmp("m2.BUSY", {3'b0, busy0}, 4'd0);

    // Short OE pulse aborts the ramp.
    oe = 1'b1;
    cyc(); cyc(); cyc();
    cmp("pulse.EN", en0, 4'b0001);
    oe = 1'b0;
    cyc();
    cmp("abort.EN", en0, 4'b0000);
    cmp("abort.BUSY", {3'b0, busy0}, 4'd1);
    cyc(); cyc();
    cmp("abort.idle", {3'b0, busy0}, 4'd0);
    cmp("abort.PU", {3'b0, pu0}, 4'd1);

    // Contention: hold A=1, force the loopback low.
    oe = 1'b1; a = 1'b1;
    repeat (8) cyc();
    cmp("pre.FAULT", {3'b0, fault0}, 4'd0);
    y_force_en = 1'b1; y_force_val = 1'b0;
    cyc();
    cmp("p0.FAULT", {3'b0, fault0}, 4'd0);
    cyc();
    cmp("p1.FAULT", {3'b0, fault0}, 4'd0);
    cyc();
    cmp("p2.FAULT", {3'b0, fault0}, 4'd1);
    fault_clr = 1'b1;
    cyc(); cyc();
    cmp("clrwin.FAULT", {3'b0, fault0}, 4'd1);
    fault_clr = 1'b0; oe = 1'b0;
    repeat (3) cyc();
    cmp("hold.FAULT", {3'b0, fault0}, 4'd1);

    // Asynchronous reset in the middle of the ramp.
    oe = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    cmp("rr.EN", en0, 4'b0011);
    #2 rstn = 1'b0;
    #1;
    cmp("arst.EN", en0, 4'b0000);
    cmp("arst.BUSY", {3'b0, busy0}, 4'd0);
    cmp("arst.FAULT", {3'b0, fault0}, 4'd0);
    @(negedge clk);
    oe = 1'b0; y_force_en = 1'b0; a = 1'b0;
    rstn = 1'b1;
    repeat (2) cyc();

    // OE re-request during BRK_OFF is ignored until IDLE.
    oe = 1'b1;
    repeat (6) cyc();
    oe = 1'b0;
    cyc();  // m
    oe = 1'b1;
    cyc();  // m+1
    cmp("bo.u1BUSY", {3'b0, busy1}, 4'd0);
    cmp("bo.u1EN", {3'b0, en1}, 4'd0);
    cmp("bo.u0BUSY", {3'b0, busy0}, 4'd1);
    cyc();  // m+2
    cmp("bo2.u1BUSY", {3'b0, busy1}, 4'd1);
    cmp("bo2.u0BUSY", {3'b0, busy0}, 4'd0);
    cyc();  // m+3
    cmp("bo3.u1EN", {3'b0, en1}, 4'd1);
    cmp("bo3.u0BUSY", {3'b0, busy0}, 4'd1);
    oe = 1'b0;
    repeat (4) cyc();

    // Randomized traffic checked by the model.
    for (int i = 0; i < 800; i++) begin
      a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) oe = ~oe;
      pu_req = 1'($urandom_range(0, 1));
      pd_req = 1'($urandom_range(0, 1));
      fault_clr = ($urandom_range(0, 7) == 0);
      y_force_en = ($urandom_range(0, 15) == 0);
      y_force_val = 1'($urandom_range(0, 1));
      cyc();
    end
    y_force_en = 1'b0; fault_clr = 1'b0; oe = 1'b0;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
